// File: rtl/waveform_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : Axis_If / Realtime_Parallel_If
// Brief    : Stream interfaces for the waveform generator: configuration in,
//            parallel per-channel sample batches out.
// Revision : 1.0 - initial release
// ============================================================================

interface Axis_If #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport Master (output valid, output data, input ready);
    modport Slave  (input valid, input data, output ready);
endinterface

interface Realtime_Parallel_If #(
    parameter int CHANNELS   = 1,
    parameter int DATA_WIDTH = 8
);
    logic [CHANNELS-1:0]                 valid;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] data;

    modport Master (output valid, output data);
    modport Slave  (input valid, input data);
endinterface

`default_nettype wire

// File: rtl/waveform_gen.sv
`default_nettype none
// ============================================================================
// Module   : waveform_gen
// Brief    : Multi-channel triangle/sawtooth/square generator with burst mode
//            and per-period trigger, PARALLEL_SAMPLES samples per dac_clk.
// Revision : 1.0 - initial release
// ============================================================================

module waveform_gen #(
    parameter int PHASE_BITS       = 32,
    parameter int CHANNELS         = 8,
    parameter int PARALLEL_SAMPLES = 16,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int CYCLE_BITS       = 16
) (
    input  logic                dac_clk,
    input  logic                dac_reset,
    Axis_If.Slave               cfg,
    Realtime_Parallel_If.Master dac_data_out,
    output logic [CHANNELS-1:0] dac_trigger,
    output logic [CHANNELS-1:0] busy
);

    localparam int c_cfg_w = PHASE_BITS + 2 + CYCLE_BITS;
    localparam int c_bus_w = PARALLEL_SAMPLES * SAMPLE_WIDTH;

    localparam logic [1:0] c_mode_off = 2'd0;
    localparam logic [1:0] c_mode_tri = 2'd1;
    localparam logic [1:0] c_mode_saw = 2'd2;
    localparam logic [1:0] c_mode_sqr = 2'd3;

    localparam logic [PHASE_BITS-1:0] c_half    = {1'b1, {(PHASE_BITS-1){1'b0}}};
    localparam logic [PHASE_BITS-1:0] c_half_m1 = {1'b0, {(PHASE_BITS-1){1'b1}}};
    // Saturation value for the period counter; always greater than any cycles.
    localparam logic [CYCLE_BITS:0]   c_sat     = {1'b1, {CYCLE_BITS{1'b0}}};

    function automatic logic [SAMPLE_WIDTH-1:0] f_wave(input logic [1:0]            mode,
                                                       input logic [PHASE_BITS-1:0] p);
        logic [PHASE_BITS-1:0] v_shl;
        logic [PHASE_BITS-1:0] v_full;
        v_shl = {p[PHASE_BITS-2:0], 1'b0};
        case (mode)
            c_mode_tri: v_full = p[PHASE_BITS-1] ? (c_half_m1 - v_shl) : (c_half + v_shl);
            c_mode_saw: v_full = p ^ c_half;
            c_mode_sqr: v_full = p[PHASE_BITS-1] ? c_half_m1 : c_half;
            default:    v_full = '0;
        endcase
        return v_full[PHASE_BITS-1 -: SAMPLE_WIDTH];
    endfunction

    logic [CHANNELS-1:0][c_bus_w-1:0] w_out_data;
    logic [CHANNELS-1:0]              w_out_valid;

    assign cfg.ready          = 1'b1;
    assign dac_data_out.data  = w_out_data;
    assign dac_data_out.valid = w_out_valid;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [PHASE_BITS-1:0] w_cfg_inc;
        logic [1:0]            w_cfg_mode;
        logic [CYCLE_BITS-1:0] w_cfg_cycles;
        logic [PARALLEL_SAMPLES-1:0][PHASE_BITS-1:0] w_mult;
        logic [PHASE_BITS-1:0] w_step;

        // Configuration and phase state
        logic [PHASE_BITS-1:0] r_inc;
        logic [1:0]            r_mode;
        logic [CYCLE_BITS-1:0] r_cycles;
        logic                  r_active;
        logic                  r_first;
        logic [PHASE_BITS-1:0] r_cycle_phase;
        logic [PHASE_BITS-1:0] r_step;
        logic [PARALLEL_SAMPLES-1:0][PHASE_BITS-1:0] r_mult;

        // Stage 1: per-sample phases
        logic                  r_s1_valid;
        logic                  r_s1_first;
        logic [PHASE_BITS-1:0] r_s1_prev0;
        logic [PARALLEL_SAMPLES-1:0][PHASE_BITS-1:0] r_s1_phase;

        // Stage 2: waveform values and wrap flags
        logic                  r_s2_valid;
        logic [PARALLEL_SAMPLES-1:0] r_s2_wrap;
        logic [PARALLEL_SAMPLES-1:0][SAMPLE_WIDTH-1:0] r_s2_wave;
        logic [PARALLEL_SAMPLES-1:0] w_wrap;
        logic [PARALLEL_SAMPLES-1:0][SAMPLE_WIDTH-1:0] w_wave;

        // Stage 3: burst masking and outputs
        logic [CYCLE_BITS:0]   r_count;
        logic [CYCLE_BITS:0]   w_count_next;
        logic [PARALLEL_SAMPLES-1:0] w_keep;
        logic                  w_trig;
        logic [c_bus_w-1:0]    w_data;
        logic [c_bus_w-1:0]    r_data;
        logic                  r_valid;
        logic                  r_trig;

        assign w_cfg_inc    = cfg.data[c*c_cfg_w +: PHASE_BITS];
        assign w_cfg_mode   = cfg.data[c*c_cfg_w + PHASE_BITS +: 2];
        assign w_cfg_cycles = cfg.data[c*c_cfg_w + PHASE_BITS + 2 +: CYCLE_BITS];

        // Sample offsets s*inc and the per-batch advance, built at config load
        always_comb begin
            w_step = '0;
            for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
                w_mult[s] = w_step;
                w_step    = w_step + w_cfg_inc;
            end
        end

        always_comb begin
            w_wrap[0] = r_s1_first || (r_s1_phase[0] < r_s1_prev0);
            for (int s = 1; s < PARALLEL_SAMPLES; s++) begin
                w_wrap[s] = r_s1_phase[s] < r_s1_phase[s-1];
            end
            for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
                w_wave[s] = f_wave(r_mode, r_s1_phase[s]);
            end
        end

        // Running period index per sample; it only grows, so sample 0 decides valid
        always_comb begin
            w_count_next = r_count;
            w_keep       = '0;
            w_trig       = 1'b0;
            w_data       = '0;
            for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
                if (r_s2_wrap[s] && (w_count_next != c_sat)) begin
                    w_count_next = w_count_next + {{CYCLE_BITS{1'b0}}, 1'b1};
                end
                w_keep[s] = (r_cycles == '0) || (w_count_next <= {1'b0, r_cycles});
                if (r_s2_wrap[s] && w_keep[s]) begin
                    w_trig = 1'b1;
                end
                if (w_keep[s]) begin
                    w_data[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_s2_wave[s];
                end
            end
        end

        always_ff @(posedge dac_clk) begin
            if (dac_reset) begin
                r_inc         <= '0;
                r_mode        <= c_mode_off;
                r_cycles      <= '0;
                r_active      <= 1'b0;
                r_first       <= 1'b0;
                r_cycle_phase <= '0;
                r_step        <= '0;
                r_mult        <= '0;
                r_s1_valid    <= 1'b0;
                r_s1_first    <= 1'b0;
                r_s1_prev0    <= '0;
                r_s1_phase    <= '0;
                r_s2_valid    <= 1'b0;
                r_s2_wrap     <= '0;
                r_s2_wave     <= '0;
                r_count       <= '0;
                r_data        <= '0;
                r_valid       <= 1'b0;
                r_trig        <= 1'b0;
            end else if (cfg.valid) begin
                // New config: reload, restart at phase 0 and drop in-flight batches
                r_inc         <= w_cfg_inc;
                r_mode        <= w_cfg_mode;
                r_cycles      <= w_cfg_cycles;
                r_active      <= (w_cfg_mode != c_mode_off);
                r_first       <= 1'b1;
                r_cycle_phase <= '0;
                r_step        <= w_step;
                r_mult        <= w_mult;
                r_s1_valid    <= 1'b0;
                r_s2_valid    <= 1'b0;
                r_count       <= '0;
                r_data        <= '0;
                r_valid       <= 1'b0;
                r_trig        <= 1'b0;
            end else begin
                r_cycle_phase <= r_cycle_phase + r_step;
                r_first       <= 1'b0;
                r_s1_valid    <= r_active;
                r_s1_first    <= r_first;
                r_s1_prev0    <= r_cycle_phase - r_inc;
                for (int s = 0; s < PARALLEL_SAMPLES; s++) begin
                    r_s1_phase[s] <= r_cycle_phase + r_mult[s];
                end
                r_s2_valid    <= r_s1_valid;
                r_s2_wrap     <= w_wrap;
                r_s2_wave     <= w_wave;
                if (r_s2_valid) begin
                    r_count <= w_count_next;
                end
                r_valid       <= r_s2_valid && w_keep[0];
                r_trig        <= r_s2_valid && w_trig;
                r_data        <= (r_s2_valid && w_keep[0]) ? w_data : '0;
            end
        end

        assign w_out_data[c]  = r_data;
        assign w_out_valid[c] = r_valid;
        assign dac_trigger[c] = r_trig;
        assign busy[c]        = r_valid;
    end

endmodule

`default_nettype wire

// File: doc/waveform_gen.md
Name: waveform_gen

Overview:
- Multi-mode periodic waveform generator for the transmit chain: triangle, sawtooth or square per channel, with burst mode (N periods, then stop).
- Sits in the dac_clk domain, upstream of the DAC sample path. Configuration arrives already CDC'd to dac_clk.
- Every configuration write restarts all channels phase-aligned at phase 0.
- Emits a per-channel trigger aligned with the output batch that starts each period.

Parameters:
PHASE_BITS, 32, phase accumulator width
CHANNELS, 8, number of output channels
PARALLEL_SAMPLES, 16, samples per channel per dac_clk cycle
SAMPLE_WIDTH, 16, output sample width (two's complement)
CYCLE_BITS, 16, width of burst period count

Ports:
dac_clk  input  1  clock; one clock domain only
dac_reset  input  1  reset, synchronous, active-high
cfg  Axis_If.Slave  CHANNELS*(PHASE_BITS+2+CYCLE_BITS)  per channel c, packed LSB-first: {cycles[CYCLE_BITS], mode[2], phase_inc[PHASE_BITS]}
dac_data_out  Realtime_Parallel_If.Master  CHANNELS x PARALLEL_SAMPLES*SAMPLE_WIDTH  sample s at bits [s*SAMPLE_WIDTH+:SAMPLE_WIDTH]
dac_trigger  output  CHANNELS  one-cycle pulse, aligned with the output batch containing a period start
busy  output  CHANNELS  channel is currently generating

Behaviour:
- Reset state: every channel idle; dac_data_out.valid=0, data=0, dac_trigger=0, busy=0; all phases=0.
- Before the first configuration, channels are idle.
- cfg.ready is tied to 1. A transfer occurs when cfg.valid=1.
- On a transfer in cycle T:
  - All channels load their new config at T+1 and restart with cycle_phase=0.
  - Samples already in the pipeline are flushed and replaced by zeros with valid=0.
- mode encoding: 0=off (idle), 1=triangle, 2=sawtooth, 3=square.
- cycles encoding: 0 = run continuously; otherwise emit exactly `cycles` periods, then go idle.
- Phase of sample s: cycle_phase + s*phase_inc, mod 2^PHASE_BITS. Multiples are precomputed at config load.
- cycle_phase advances by PARALLEL_SAMPLES*phase_inc per cycle, mod 2^PHASE_BITS.
- Waveform functions, evaluated on phase p at full PHASE_BITS precision; output is the top SAMPLE_WIDTH bits:
  - triangle: if p[MSB]=0, out = 2^(PHASE_BITS-1) + (p[MSB-1:0]<<1); else out = (2^(PHASE_BITS-1)-1) - (p[MSB-1:0]<<1). Truncate mod 2^PHASE_BITS.
  - sawtooth: out = p XOR 2^(PHASE_BITS-1).
  - square: out = min code (1000…0) if p[MSB]=0, else max code (0111…1).
  - All three start at min code at phase 0.
- Period start (wrap):
  - Sample 0 of the first batch after restart counts as a period start.
  - Any later sample whose phase is unsigned-less-than the preceding sample's phase (across batch boundaries too) is a period start.
  - Wraps per sample ≤1 always; several per batch are allowed.
- Period index of a sample = running count of period starts up to and including that sample.
- Burst masking (cycles≠0):
  - Samples with period index > cycles output 0.
  - valid stays 1 for every batch that contains at least one sample with index ≤ cycles, and drops from the next batch onward.
  - busy falls with valid.
  - The wrap counter saturates; it must not roll over.
- dac_trigger[c] pulses in the same cycle as any batch that contains a period start with index ≤ cycles (or any period start when cycles=0).
- Latency: the first batch after a transfer at T (phases 0, inc, …, (P-1)*inc) appears with valid=1 at cycle T+4.
  - busy rises at T+4.
  - The pipeline is fixed at 3 stages after config load.
- phase_inc=0: constant phase-0 value, one trigger, never completes a burst (busy stays high).
- mode=off on a channel: that channel is idle (valid=0, data=0); other channels are unaffected.
- Reset mid-operation: all outputs return to reset values in the next cycle; the config is discarded.
- A config arriving in the same cycle as reset is ignored.

Test Plan:
(All use PHASE_BITS=8, CHANNELS=2, PARALLEL_SAMPLES=4, SAMPLE_WIDTH=8, CYCLE_BITS=4.)
- Triangle, inc=16, cycles=0:
  - First batch at T+4 = 80,A0,C0,E0; then 00,20,40,60; then 7F,5F,3F,1F.
  - Trigger on batches 0,4,8,…; valid never drops.
- Sawtooth, inc=64, cycles=3:
  - Batch = 80,C0,00,40, repeated.
  - Trigger every batch for 3 batches, then valid=0, busy=0, data=0.
- Square, inc=32, continuous: batches alternate 80,80,80,80 / 7F,7F,7F,7F.
- Mid-batch burst end, triangle, inc=96, cycles=1:
  - Batch 0 = 80,40,FF,00 (sample 3 masked); trigger on batch 0 only.
  - valid=0 from batch 1.
- Channel independence and restart:
  - ch0 triangle, ch1 off: ch1 valid=0 throughout.
  - A new config mid-run restarts ch0 at 80 exactly 4 cycles later, with no stale samples in between.
- Reset during a burst: next cycle valid=0, trigger=0, busy=0; stays idle until the next cfg transfer.
